hdmi_i2c_config: RTL and testbench

Power-up and on-demand configuration sequencer for the board's HDMI transmitter. It holds the transmitter in reset and then releases it. It then walks a register table and writes each entry over an open-drain I2C master it contains (SCL/SDA), retrying entries that are NACKed. It sits in the board top level beside the video path, driving HDMI_RST, HDMI_SCL and HDMI_SDA through open-drain pads.

---
 rtl/hdmi_i2c_config.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_hdmi_i2c_config.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_config.sv
// hdmi_i2c_config
//
// Power-up and on-demand configuration sequencer for the HDMI transmitter.
// It holds the transmitter in reset, releases it, waits, and then writes
// every entry of an external register table over a built-in open-drain I2C
// master. Entries that are NACKed are retried.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   start       one-cycle pulse, re-runs the table when not busy
//   tbl_addr    table index to the external synchronous ROM
//   tbl_data    {reg, value}, valid one cycle after tbl_addr changes
//   hdmi_rst_n  transmitter reset, active low
//   scl_oe      1 = pull SCL low
//   sda_oe      1 = pull SDA low
//   sda_i       SDA pad input, already synchronised
//   busy        sequence in progress
//   done        sticky, all entries written
//   error       sticky, an entry failed after all retries
//
// State      | meaning
// -----------+------------------------------------------------------------
// RST_HOLD   | hdmi_rst_n low for RST_CYCLES, then high for RST_CYCLES more
// IDLE       | bus idle, waiting for start
// LOAD       | one cycle of ROM latency, then latch {reg, value}
// START      | quarter idle, then SDA low with SCL high
// BYTE       | shifting eight bits out, MSB first
// ACK        | SDA released, sampled on quarter q2
// STOP       | SDA low, SCL released, SDA released
// GAP        | 4*DIV clocks of bus idle, then next entry / retry / finish
// DONE       | whole table written
// FAIL       | an entry exhausted its retries

module hdmi_i2c_config #(
    parameter int         CLK_HZ      = 50000000,
    parameter int         I2C_HZ      = 100000,
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         NUM_ENTRIES = 32,
    parameter int         RST_CYCLES  = 1000,
    parameter int         RETRIES     = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        hdmi_rst_n,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int DIV     = CLK_HZ / (4 * I2C_HZ);
    localparam int QCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_CYC = 4 * DIV;
    localparam int CNT_MAX = (GAP_CYC > RST_CYCLES) ? GAP_CYC : RST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(RETRIES + 2);

    localparam logic [QCW-1:0] Q_LAST     = QCW'(DIV - 1);
    localparam logic [CW-1:0]  RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LOAD   = CW'(GAP_CYC - 1);
    localparam logic [7:0]     LAST_ENTRY = 8'(NUM_ENTRIES - 1);
    localparam logic [TW-1:0]  MAX_RETRY  = TW'(RETRIES);
    localparam logic [7:0]     ADDR_BYTE  = {DEV_ADDR, 1'b0};

    typedef enum logic [3:0] {
        S_RST_HOLD,
        S_IDLE,
        S_LOAD,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_busy_next;

    logic [QCW-1:0]  r_qcnt;
    logic [1:0]      r_q;
    logic [2:0]      r_bit;
    logic [1:0]      r_byte;
    logic [7:0]      r_shift;
    logic [7:0]      r_reg;
    logic [7:0]      r_val;
    logic            r_nack;
    logic [TW-1:0]   r_tries;
    logic [CW-1:0]   r_cnt;
    logic            r_load_wait;
    logic [7:0]      r_tbl_addr;
    logic            r_hdmi_rst_n;
    logic            r_scl_oe;
    logic            r_sda_oe;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic            w_tick;
    logic            w_cnt_tc;
    logic            w_last_entry;
    logic            w_can_retry;
    logic [7:0]      w_next_byte;

    assign w_tick       = (r_qcnt == Q_LAST);
    assign w_cnt_tc     = (r_cnt == '0);
    assign w_last_entry = (r_tbl_addr == LAST_ENTRY);
    assign w_can_retry  = (r_tries < MAX_RETRY);
    assign w_next_byte  = (r_byte == 2'd0) ? r_reg : r_val;

    assign tbl_addr   = r_tbl_addr;
    assign hdmi_rst_n = r_hdmi_rst_n;
    assign scl_oe     = r_scl_oe;
    assign sda_oe     = r_sda_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = 1'b0;
        case (r_state)
            S_RST_HOLD: if (w_cnt_tc && r_hdmi_rst_n) w_state_next = S_LOAD;
            S_IDLE, S_DONE, S_FAIL: if (start) w_state_next = S_LOAD;
            S_LOAD:     if (r_load_wait) w_state_next = S_START;
            S_START:    if (w_tick && r_q == 2'd1) w_state_next = S_BYTE;
            S_BYTE:     if (w_tick && r_q == 2'd3 && r_bit == 3'd0) w_state_next = S_ACK;
            S_ACK: begin
                if (w_tick && r_q == 2'd3) begin
                    w_state_next = (r_nack || r_byte == 2'd2) ? S_STOP : S_BYTE;
                end
            end
            S_STOP:     if (w_tick && r_q == 2'd1) w_state_next = S_GAP;
            S_GAP: begin
                if (w_cnt_tc) begin
                    if (r_nack) begin
                        w_state_next = w_can_retry ? S_LOAD : S_FAIL;
                    end else begin
                        w_state_next = w_last_entry ? S_DONE : S_LOAD;
                    end
                end
            end
            default:    w_state_next = S_RST_HOLD;
        endcase
        w_busy_next = !(w_state_next == S_IDLE || w_state_next == S_DONE ||
                        w_state_next == S_FAIL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_qcnt       <= '0;
            r_q          <= 2'd0;
            r_bit        <= 3'd0;
            r_byte       <= 2'd0;
            r_shift      <= 8'd0;
            r_reg        <= 8'd0;
            r_val        <= 8'd0;
            r_nack       <= 1'b0;
            r_tries      <= '0;
            r_cnt        <= RST_LOAD;
            r_load_wait  <= 1'b0;
            r_tbl_addr   <= 8'd0;
            r_hdmi_rst_n <= 1'b0;
            r_scl_oe     <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_busy <= w_busy_next;

            // Quarter-bit divider only runs while the bus is being driven so
            // every transaction starts on a fresh quarter.
            if (r_state == S_START || r_state == S_BYTE ||
                r_state == S_ACK   || r_state == S_STOP) begin
                r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
            end else begin
                r_qcnt <= '0;
            end

            case (r_state)
                S_RST_HOLD: begin
                    if (w_cnt_tc) begin
                        if (!r_hdmi_rst_n) begin
                            r_hdmi_rst_n <= 1'b1;
                            r_cnt        <= RST_LOAD;
                        end else begin
                            r_tbl_addr <= 8'd0;
                            r_tries    <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_tbl_addr <= 8'd0;
                        r_tries    <= '0;
                    end
                end

                S_LOAD: begin
                    if (!r_load_wait) begin
                        r_load_wait <= 1'b1;
                    end else begin
                        r_load_wait <= 1'b0;
                        r_reg       <= tbl_data[15:8];
                        r_val       <= tbl_data[7:0];
                        r_nack      <= 1'b0;
                        r_q         <= 2'd0;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        if (r_q == 2'd0) begin
                            r_sda_oe <= 1'b1;
                            r_q      <= 2'd1;
                        end else begin
                            // SCL falls and the first address bit goes out together.
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= ~ADDR_BYTE[7];
                            r_shift  <= ADDR_BYTE;
                            r_bit    <= 3'd7;
                            r_byte   <= 2'd0;
                            r_q      <= 2'd0;
                        end
                    end
                end

                S_BYTE: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl_oe <= 1'b0;
                            2'd2: r_scl_oe <= 1'b1;
                            2'd3: begin
                                if (r_bit == 3'd0) begin
                                    r_sda_oe <= 1'b0;
                                end else begin
                                    r_sda_oe <= ~r_shift[6];
                                    r_shift  <= {r_shift[6:0], 1'b0};
                                    r_bit    <= r_bit - 3'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACK: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl_oe <= 1'b0;
                            2'd2: begin
                                r_scl_oe <= 1'b1;
                                r_nack   <= sda_i;
                            end
                            2'd3: begin
                                if (r_nack || r_byte == 2'd2) begin
                                    r_sda_oe <= 1'b1;
                                end else begin
                                    r_shift  <= w_next_byte;
                                    r_sda_oe <= ~w_next_byte[7];
                                    r_bit    <= 3'd7;
                                    r_byte   <= r_byte + 2'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        if (r_q == 2'd0) begin
                            r_scl_oe <= 1'b0;
                            r_q      <= 2'd1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_q      <= 2'd0;
                            r_cnt    <= GAP_LOAD;
                        end
                    end
                end

                S_GAP: begin
                    if (w_cnt_tc) begin
                        if (r_nack) begin
                            if (w_can_retry) begin
                                r_tries <= r_tries + 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end else if (w_last_entry) begin
                            r_done <= 1'b1;
                        end else begin
                            r_tbl_addr <= r_tbl_addr + 8'd1;
                            r_tries    <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_i2c_config.sv
module tb_hdmi_i2c_config;

    localparam int         N       = 3;
    localparam int         RETRIES = 3;
    localparam logic [7:0] ADDR_W  = 8'h72;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        hdmi_rst_n;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_i;
    logic        busy;
    logic        done;
    logic        error;
    logic        pull;

    hdmi_i2c_config #(
        .CLK_HZ      (800000),
        .I2C_HZ      (100000),
        .DEV_ADDR    (7'h39),
        .NUM_ENTRIES (N),
        .RST_CYCLES  (10),
        .RETRIES     (RETRIES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .hdmi_rst_n (hdmi_rst_n),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_i      (sda_i),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    assign sda_i = !(sda_oe || pull);

    logic [15:0] rom [0:N-1];
    always @(posedge clk) tbl_data <= (tbl_addr < 8'(N)) ? rom[tbl_addr[1:0]] : 16'h0000;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nack_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];
    int          dec [0:N-1][0:RETRIES];
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int n, input logic [7:0] b0,
                                         input logic [7:0] b1, input logic [7:0] b2);
        return {8'(n), (n >= 1) ? b0 : 8'h00, (n >= 2) ? b1 : 8'h00, (n >= 3) ? b2 : 8'h00};
    endfunction

    // Transaction-level model: each entry is attempted until the slave ACKs
    // all three bytes or RETRIES+1 attempts have been NACKed.
    task automatic build_model();
        nack_q.delete();
        exp_q.delete();
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_addr = 8'(N - 1);
        for (int e = 0; e < N; e++) begin
            bit ok;
            ok = 1'b0;
            for (int a = 0; a <= RETRIES; a++) begin
                int d;
                d = dec[e][a];
                nack_q.push_back(d);
                exp_q.push_back(pack((d == 0) ? 3 : d, ADDR_W, rom[e][15:8], rom[e][7:0]));
                if (d == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                exp_addr = 8'(e);
                return;
            end
        end
    endtask

    task automatic all_ack();
        for (int e = 0; e < N; e++)
            for (int a = 0; a <= RETRIES; a++) dec[e][a] = 0;
    endtask

    // I2C slave: decodes START/STOP, shifts bits on SCL rise, drives ACK per plan.
    logic       p_scl, p_sda, scl_l, sda_l, in_txn;
    int         bitcnt, nbytes, cur_nack;
    logic [7:0] sh;
    logic [7:0] rxb [0:2];

    initial begin
        pull = 1'b0; p_scl = 1'b1; p_sda = 1'b1; in_txn = 1'b0;
        bitcnt = 0; nbytes = 0; cur_nack = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            scl_l = !scl_oe;
            sda_l = !(sda_oe || pull);
            if (!reset_n) begin
                in_txn = 1'b0; bitcnt = 0; pull = 1'b0;
            end else if (p_scl && scl_l && p_sda && !sda_l) begin
                in_txn = 1'b1; bitcnt = 0; nbytes = 0; sh = 8'h00;
                for (int i = 0; i < 3; i++) rxb[i] = 8'h00;
                cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 0;
            end else if (p_scl && scl_l && !p_sda && sda_l) begin
                if (in_txn) rx_q.push_back({8'(nbytes), rxb[0], rxb[1], rxb[2]});
                in_txn = 1'b0;
            end else if (in_txn && !p_scl && scl_l) begin
                if (bitcnt < 8) begin
                    sh = {sh[6:0], sda_l};
                    bitcnt++;
                end
            end else if (in_txn && p_scl && !scl_l) begin
                if (bitcnt == 8) begin
                    if (nbytes < 3) rxb[nbytes] = sh;
                    pull   = (cur_nack != nbytes + 1);
                    bitcnt = 9;
                end else if (bitcnt == 9) begin
                    pull   = 1'b0;
                    nbytes++;
                    bitcnt = 0;
                end
            end
            p_scl = scl_l;
            p_sda = !(sda_oe || pull);
        end
    end

    task automatic wait_end();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!busy && (done || error)) begin
                got = 1'b1;
                break;
            end
        end
        check("end_reached", 32'(got), 1);
    endtask

    task automatic check_result(input string tag);
        int n;
        check({tag, "_ntxn"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_txn%0d", tag, i), rx_q[i], exp_q[i]);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_addr"}, 32'(tbl_addr), 32'(exp_addr));
        check({tag, "_bus"}, 32'({scl_oe, sda_oe}), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("sticky_clr", 32'({done, error}), 0);
        check("busy_on", 32'(busy), 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag);
        rx_q.delete();
        build_model();
        pulse_start();
        wait_end();
        check_result(tag);
    endtask

    initial begin
        int first_k;
        logic found;
        reset_n = 1'b0;
        start   = 1'b0;
        rom[0] = 16'h4110;
        rom[1] = 16'h9803;
        rom[2] = 16'hD6C0;
        all_ack();
        build_model();
        rx_q.delete();

        #23;
        check("rst_hdmi", 32'(hdmi_rst_n), 0);
        check("rst_bus", 32'({scl_oe, sda_oe}), 0);
        check("rst_flags", 32'({busy, done, error}), 0);
        check("rst_addr", 32'(tbl_addr), 0);

        @(negedge clk);
        reset_n = 1'b1;
        first_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)  check("busy_first_clk", 32'(busy), 1);
            if (k == 9)  check("hdmi_low_9", 32'(hdmi_rst_n), 0);
            if (k == 10) check("hdmi_high_10", 32'(hdmi_rst_n), 1);
            if (sda_oe && first_k == 0) first_k = k;
        end
        check("start_window", 32'(first_k > 22 && first_k <= 30), 1);
        wait_end();
        check_result("boot");

        // start during busy is ignored: still one pass over the table
        rx_q.delete();
        build_model();
        pulse_start();
        repeat (100) @(negedge clk);
        check("busy_mid", 32'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end();
        check_result("rerun");

        all_ack();
        dec[1][0] = 1;
        dec[1][1] = 1;
        run("nack_addr");

        all_ack();
        for (int a = 0; a <= RETRIES; a++) dec[0][a] = 3;
        run("nack_fail");

        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < N; e++) begin
                rom[e] = 16'($urandom);
                for (int a = 0; a <= RETRIES; a++)
                    dec[e][a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            if ($urandom_range(0, 3) == 0) begin
                int fe;
                fe = int'($urandom_range(0, N - 1));
                for (int a = 0; a <= RETRIES; a++) dec[fe][a] = int'($urandom_range(1, 3));
            end
            run($sformatf("rand%0d", r));
        end

        // reset in the middle of a byte
        all_ack();
        rx_q.delete();
        build_model();
        pulse_start();
        repeat ($urandom_range(30, 300)) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (scl_oe && busy) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("scl_low_found", 32'(found), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_bus", 32'({scl_oe, sda_oe}), 0);
        check("async_hdmi", 32'(hdmi_rst_n), 0);
        repeat (5) @(negedge clk);
        rx_q.delete();
        build_model();
        reset_n = 1'b1;
        wait_end();
        check_result("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
